// File: rtl/gcd_operand_feeder_if.sv
// Handshake and core-side bus bundle for gcd_operand_feeder.
// The master modport is the feeder; the slave modport is its environment (producer, core, consumer).
interface gcd_operand_feeder_if #(
  parameter int WIDTH = 16
);
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_data;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_gcd;
  logic             res_err;
  logic             busy;

  modport master (
    input  op_valid, op_a, op_b, gcd_done, gcd_result, res_ready,
    output op_ready, gcd_start, gcd_data, res_valid, res_gcd, res_err, busy
  );

  modport slave (
    output op_valid, op_a, op_b, gcd_done, gcd_result, res_ready,
    input  op_ready, gcd_start, gcd_data, res_valid, res_gcd, res_err, busy
  );
endinterface

// File: rtl/gcd_operand_feeder.sv
// Sequences an operand pair onto the GCD core's shared data bus, waits for done under a
// watchdog, and presents the result; zero operands are answered without touching the core.
module gcd_operand_feeder #(
  parameter int WIDTH   = 16,
  parameter int A_HOLD  = 2,
  parameter int B_HOLD  = 2,
  parameter int TIMEOUT = 1024
) (
   input logic                  clk,
   input logic                  reset,
   gcd_operand_feeder_if.master bus
);

   typedef enum logic [2:0] {S_IDLE, S_FEED_A, S_FEED_B, S_WAIT, S_OUT} state_e;

   // One counter serves both hold phases and the watchdog, so size it for the largest.
   localparam int HOLD_MAX = (A_HOLD > B_HOLD) ? A_HOLD : B_HOLD;
   localparam int CNT_MAX  = (TIMEOUT > HOLD_MAX) ? TIMEOUT : HOLD_MAX;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] A_LAST  = CNT_W'(A_HOLD - 1);
   localparam logic [CNT_W-1:0] B_LAST  = CNT_W'(B_HOLD - 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic [WIDTH-1:0] res_q,   res_d;
   logic             err_q,   err_d;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.op_valid) begin
               a_d   = bus.op_a;
               b_d   = bus.op_b;
               cnt_d = '0;
               // The core never terminates on a zero operand, so answer it here.
               if (bus.op_a == '0 || bus.op_b == '0) begin
                  res_d   = bus.op_a | bus.op_b;
                  err_d   = 1'b0;
                  state_d = S_OUT;
               end else begin
                  state_d = S_FEED_A;
               end
            end
         end
         S_FEED_A: begin
            if (cnt_q == A_LAST) begin
               cnt_d   = '0;
               state_d = S_FEED_B;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_FEED_B: begin
            if (cnt_q == B_LAST) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_WAIT: begin
            if (bus.gcd_done) begin
               res_d   = bus.gcd_result;
               err_d   = 1'b0;
               state_d = S_OUT;
            end else if (cnt_q == TO_LAST) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = S_OUT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_OUT: begin
            if (bus.res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.op_ready  = 1'b0;
      bus.gcd_start = 1'b0;
      bus.gcd_data  = '0;
      bus.res_valid = 1'b0;
      bus.res_gcd   = '0;
      bus.res_err   = 1'b0;
      bus.busy      = (state_q != S_IDLE);
      unique case (state_q)
         S_IDLE:   bus.op_ready = 1'b1;
         S_FEED_A: begin
            bus.gcd_data  = a_q;
            bus.gcd_start = (cnt_q == '0);
         end
         S_FEED_B: bus.gcd_data = b_q;
         S_OUT: begin
            bus.res_valid = 1'b1;
            bus.res_gcd   = res_q;
            bus.res_err   = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Directed bench for gcd_operand_feeder: a behavioural subtractive GCD core on one instance,
// and a second instance with a short watchdog and done tied low.
module tb_gcd_operand_feeder;

   localparam int W = 16;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   int   start_cnt;

   gcd_operand_feeder_if #(.WIDTH(W)) m ();
   gcd_operand_feeder_if #(.WIDTH(W)) t ();

   gcd_operand_feeder #(.WIDTH(W), .A_HOLD(2), .B_HOLD(2), .TIMEOUT(1024)) u_main (
      .clk   (clk),
      .reset (rst_n),
      .bus   (m.master)
   );

   gcd_operand_feeder #(.WIDTH(W), .A_HOLD(2), .B_HOLD(2), .TIMEOUT(16)) u_tmo (
      .clk   (clk),
      .reset (rst_n),
      .bus   (t.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural core: loads A on the start edge, B two edges later, then subtracts to equality.
   logic [W-1:0] cx, cy;
   logic         cdone;
   int           cphase;
   int           ccnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cx <= '0; cy <= '0; cdone <= 1'b0; cphase <= 0; ccnt <= 0;
      end else if (m.gcd_start) begin
         cx <= m.gcd_data; cdone <= 1'b0; cphase <= 1; ccnt <= 1;
      end else if (cphase == 1) begin
         if (ccnt == 2) begin
            cy <= m.gcd_data;
            cphase <= 2;
         end
         ccnt <= ccnt + 1;
      end else if (cphase == 2) begin
         if (cx == cy) begin
            cdone <= 1'b1;
            cphase <= 0;
         end else if (cx > cy) cx <= cx - cy;
         else cy <= cy - cx;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) start_cnt <= 0;
      else if (m.gcd_start) start_cnt <= start_cnt + 1;
   end

   assign m.gcd_done   = cdone;
   assign m.gcd_result = cx;
   assign t.gcd_done   = 1'b0;
   assign t.gcd_result = '0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_res(output bit ok);
      int n;
      n = 0;
      while (!m.res_valid && n < 200) begin
         tick();
         n++;
      end
      ok = m.res_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m.op_valid = 1'b0; m.op_a = '0; m.op_b = '0; m.res_ready = 1'b1;
      t.op_valid = 1'b0; t.op_a = '0; t.op_b = '0; t.res_ready = 1'b1;
      #12;
      n_vec++;
      if ({m.op_ready, m.busy, m.gcd_start, m.res_valid, m.res_err} !== 5'b10000) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 10000", {m.op_ready, m.busy, m.gcd_start, m.res_valid, m.res_err});
      end
      n_vec++;
      if (m.gcd_data !== 16'd0 || m.res_gcd !== 16'd0) begin
         n_err++;
         $display("FAIL reset_data: gcd_data=%0d res_gcd=%0d want 0,0", m.gcd_data, m.res_gcd);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_core_path();
      int       s0;
      int       n;
      bit       ok;
      logic [W-1:0] exp_data [4];
      exp_data[0] = 16'd48; exp_data[1] = 16'd48; exp_data[2] = 16'd18; exp_data[3] = 16'd18;
      s0 = start_cnt;
      m.op_valid = 1'b1; m.op_a = 16'd48; m.op_b = 16'd18; m.res_ready = 1'b1;
      n_vec++;
      if (m.op_ready !== 1'b1) begin n_err++; $display("FAIL core_op_ready: got %b want 1", m.op_ready); end
      tick();
      m.op_valid = 1'b0; m.op_a = 16'hdead; m.op_b = 16'hbeef;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (m.gcd_data !== exp_data[i] || m.gcd_start !== (i == 0)) begin
            n_err++;
            $display("FAIL core_feed[%0d]: data=%0d start=%b want data=%0d start=%b", i, m.gcd_data, m.gcd_start, exp_data[i], (i == 0));
         end
         tick();
      end
      n_vec++;
      if (m.gcd_data !== 16'd0 || m.busy !== 1'b1) begin
         n_err++;
         $display("FAIL core_wait_entry: data=%0d busy=%b want 0,1", m.gcd_data, m.busy);
      end
      n = 0;
      while (!cdone && n < 200) begin tick(); n++; end
      n_vec++;
      if (!cdone || m.res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL core_done_seen: done=%b res_valid=%b want 1,0", cdone, m.res_valid);
      end
      tick();
      n_vec++;
      if (m.res_valid !== 1'b1 || m.res_gcd !== 16'd6 || m.res_err !== 1'b0) begin
         n_err++;
         $display("FAIL core_result: valid=%b gcd=%0d err=%b want 1,6,0", m.res_valid, m.res_gcd, m.res_err);
      end
      tick();
      n_vec++;
      if (m.op_ready !== 1'b1 || start_cnt - s0 !== 1) begin
         n_err++;
         $display("FAIL core_after: op_ready=%b starts=%0d want 1,1", m.op_ready, start_cnt - s0);
      end
      ok = 1'b1;
   endtask

   task automatic test_bypass();
      int s0;
      logic [W-1:0] va [3];
      logic [W-1:0] vb [3];
      logic [W-1:0] ve [3];
      va[0] = 16'd0;  vb[0] = 16'd35; ve[0] = 16'd35;
      va[1] = 16'd0;  vb[1] = 16'd0;  ve[1] = 16'd0;
      va[2] = 16'd35; vb[2] = 16'd0;  ve[2] = 16'd35;
      s0 = start_cnt;
      m.res_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         m.op_valid = 1'b1; m.op_a = va[i]; m.op_b = vb[i];
         tick();
         m.op_valid = 1'b0;
         n_vec++;
         if (m.res_valid !== 1'b1 || m.res_gcd !== ve[i] || m.res_err !== 1'b0 || m.gcd_start !== 1'b0) begin
            n_err++;
            $display("FAIL bypass[%0d]: valid=%b gcd=%0d err=%b start=%b want 1,%0d,0,0",
                     i, m.res_valid, m.res_gcd, m.res_err, m.gcd_start, ve[i]);
         end
         tick();
      end
      n_vec++;
      if (start_cnt !== s0) begin
         n_err++;
         $display("FAIL bypass_no_start: starts=%0d want %0d", start_cnt, s0);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      m.res_ready = 1'b0;
      m.op_valid = 1'b1; m.op_a = 16'd81; m.op_b = 16'd27;
      tick();
      // Keep offering a different pair while busy; it must be ignored.
      m.op_a = 16'd7; m.op_b = 16'd7;
      wait_res(ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL bp_timeout: res_valid never rose"); end
      for (int i = 0; i < 10; i++) begin
         n_vec++;
         if (m.res_valid !== 1'b1 || m.res_gcd !== 16'd27 || m.op_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: valid=%b gcd=%0d op_ready=%b want 1,27,0", i, m.res_valid, m.res_gcd, m.op_ready);
         end
         tick();
      end
      m.op_valid = 1'b0;
      m.res_ready = 1'b1;
      tick();
      n_vec++;
      if (m.res_valid !== 1'b0 || m.op_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: valid=%b op_ready=%b want 0,1", m.res_valid, m.op_ready);
      end
   endtask

   task automatic test_timeout();
      t.res_ready = 1'b1;
      t.op_valid = 1'b1; t.op_a = 16'd5; t.op_b = 16'd3;
      tick();
      t.op_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 16; i++) begin
         n_vec++;
         if (t.res_valid !== 1'b0 || t.busy !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_wait[%0d]: valid=%b busy=%b want 0,1", i, t.res_valid, t.busy);
         end
         tick();
      end
      n_vec++;
      if (t.res_valid !== 1'b1 || t.res_err !== 1'b1 || t.res_gcd !== 16'd0) begin
         n_err++;
         $display("FAIL tmo_result: valid=%b err=%b gcd=%0d want 1,1,0", t.res_valid, t.res_err, t.res_gcd);
      end
      tick();
      n_vec++;
      if (t.op_ready !== 1'b1 || t.res_err !== 1'b0) begin
         n_err++;
         $display("FAIL tmo_after: op_ready=%b err=%b want 1,0", t.op_ready, t.res_err);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      m.res_ready = 1'b1;
      m.op_valid = 1'b1; m.op_a = 16'd48; m.op_b = 16'd18;
      tick();
      m.op_valid = 1'b0;
      tick();
      tick();
      n_vec++;
      if (m.gcd_data !== 16'd18) begin
         n_err++;
         $display("FAIL rmid_in_feed_b: data=%0d want 18", m.gcd_data);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (m.op_ready !== 1'b1 || m.gcd_start !== 1'b0 || m.gcd_data !== 16'd0 || m.res_valid !== 1'b0 || m.busy !== 1'b0) begin
         n_err++;
         $display("FAIL rmid_reset: op_ready=%b start=%b data=%0d valid=%b busy=%b want 1,0,0,0,0",
                  m.op_ready, m.gcd_start, m.gcd_data, m.res_valid, m.busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      m.op_valid = 1'b1; m.op_a = 16'd12; m.op_b = 16'd8;
      tick();
      m.op_valid = 1'b0;
      wait_res(ok);
      n_vec++;
      if (!ok || m.res_gcd !== 16'd4 || m.res_err !== 1'b0) begin
         n_err++;
         $display("FAIL rmid_next: valid=%b gcd=%0d err=%b want 1,4,0", m.res_valid, m.res_gcd, m.res_err);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] qa [3];
      logic [W-1:0] qb [3];
      logic [W-1:0] qe [3];
      logic [W-1:0] got [$];
      int idx;
      int n;
      bit acc;
      qa[0] = 16'd48;  qb[0] = 16'd18; qe[0] = 16'd6;
      qa[1] = 16'd17;  qb[1] = 16'd5;  qe[1] = 16'd1;
      qa[2] = 16'd100; qb[2] = 16'd75; qe[2] = 16'd25;
      idx = 0;
      n = 0;
      m.res_ready = 1'b1;
      m.op_valid = 1'b1; m.op_a = qa[0]; m.op_b = qb[0];
      while (got.size() < 3 && n < 1000) begin
         acc = m.op_valid && m.op_ready;
         if (m.res_valid) got.push_back(m.res_gcd);
         tick();
         n++;
         if (acc) begin
            idx++;
            if (idx >= 3) m.op_valid = 1'b0;
            else begin m.op_a = qa[idx]; m.op_b = qb[idx]; end
         end
      end
      m.op_valid = 1'b0;
      n_vec++;
      if (got.size() !== 3) begin
         n_err++;
         $display("FAIL b2b_count: got %0d results want 3", got.size());
      end
      for (int i = 0; i < 3; i++) begin
         if (i < got.size()) begin
            n_vec++;
            if (got[i] !== qe[i]) begin
               n_err++;
               $display("FAIL b2b_result[%0d]: got %0d want %0d", i, got[i], qe[i]);
            end
         end
      end
      for (int i = 0; i < 5; i++) tick();
      n_vec++;
      if (m.res_valid !== 1'b0 || m.op_ready !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_idle: valid=%b op_ready=%b want 0,1", m.res_valid, m.op_ready);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_core_path();
      test_bypass();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
